// File: rtl/dc_flit_assembler_if.sv
// Flit-in / message-out bundle between the ring-node FIFO path and the data cache.
//   master : flit source and cache consumer side (drives flits and dc_done_access)
//   slave  : the assembler (drives in_ready_dc and the download message)
// Ports carried:
//   IN_flit_dc, v_IN_flit_dc, In_flit_ctrl_dc, in_ready_dc   flit handshake
//   dc_done_access                                            cache consumes message
//   v_dc_download, dc_download_flits/len/err                  presented message
//   dc_download_state, dc_drop                                status
interface dc_flit_assembler_if #(
  parameter int unsigned FLIT_W    = 16,
  parameter int unsigned MAX_FLITS = 9,
  parameter int unsigned LEN_W     = 4
);
  logic [FLIT_W-1:0]           IN_flit_dc;
  logic                        v_IN_flit_dc;
  logic [1:0]                  In_flit_ctrl_dc;
  logic                        in_ready_dc;
  logic                        dc_done_access;
  logic                        v_dc_download;
  logic [FLIT_W*MAX_FLITS-1:0] dc_download_flits;
  logic [LEN_W-1:0]            dc_download_len;
  logic                        dc_download_err;
  logic [1:0]                  dc_download_state;
  logic                        dc_drop;

  modport master (
    output IN_flit_dc, v_IN_flit_dc, In_flit_ctrl_dc, dc_done_access,
    input  in_ready_dc, v_dc_download, dc_download_flits, dc_download_len,
           dc_download_err, dc_download_state, dc_drop
  );

  modport slave (
    input  IN_flit_dc, v_IN_flit_dc, In_flit_ctrl_dc, dc_done_access,
    output in_ready_dc, v_dc_download, dc_download_flits, dc_download_len,
           dc_download_err, dc_download_state, dc_drop
  );
endinterface

// File: rtl/dc_flit_assembler.sv
// Packs FLIT_W-bit flits into one FLIT_W*MAX_FLITS message for the data cache.
// Framing comes from the 2-bit control code (01 head, 10 body, 11 tail, 00 single).
// An assembly register (A) collects the message; an output register (O) presents it,
// so a new message can assemble while the cache still holds the previous one.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dc_flit_assembler_if.slave: flit handshake in, download message and status out
module dc_flit_assembler #(
  parameter int unsigned FLIT_W    = 16,
  parameter int unsigned MAX_FLITS = 9,
  parameter int unsigned LEN_W     = 4
) (
  input logic                clk,
  input logic                rst,
  dc_flit_assembler_if.slave bus
);

  localparam int unsigned      MsgW   = FLIT_W * MAX_FLITS;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_FLITS);

  localparam logic [1:0] CtrlSingle = 2'b00;
  localparam logic [1:0] CtrlHead   = 2'b01;
  localparam logic [1:0] CtrlTail   = 2'b11;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StAssemble = 2'b01,
    StOverflow = 2'b10,
    StHold     = 2'b11
  } state_e;

  // Slot k lives at [FLIT_W*(MAX_FLITS-k)-1 -: FLIT_W]; the head flit is in the MSBs.
  function automatic logic [MsgW-1:0] put_flit(input logic [MsgW-1:0]   msg,
                                               input logic [LEN_W-1:0]  slot,
                                               input logic [FLIT_W-1:0] flit);
    logic [MsgW-1:0] res;
    res = msg;
    for (int unsigned i = 0; i < MAX_FLITS; i++) begin
      if (slot == LEN_W'(i)) res[FLIT_W*(MAX_FLITS-i)-1 -: FLIT_W] = flit;
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [MsgW-1:0]  a_data_q, a_data_d;
  logic [LEN_W-1:0] a_cnt_q, a_cnt_d;
  logic             a_err_q, a_err_d;
  logic             o_valid_q, o_valid_d;
  logic [MsgW-1:0]  o_data_q, o_data_d;
  logic [LEN_W-1:0] o_len_q, o_len_d;
  logic             o_err_q, o_err_d;
  logic             drop_q, drop_d;

  // Completed message candidate, either built this cycle or taken from A out of HOLD.
  logic             complete;
  logic             start_new;
  logic [MsgW-1:0]  c_data;
  logic [LEN_W-1:0] c_len;
  logic             c_err;
  logic             o_free;

  logic [1:0]        ctrl;
  logic [FLIT_W-1:0] flit;
  logic              flit_v;

  assign ctrl   = bus.In_flit_ctrl_dc;
  assign flit   = bus.IN_flit_dc;
  assign flit_v = bus.v_IN_flit_dc;
  assign o_free = !o_valid_q || bus.dc_done_access;

  always_comb begin
    state_d   = state_q;
    a_data_d  = a_data_q;
    a_cnt_d   = a_cnt_q;
    a_err_d   = a_err_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_len_d   = o_len_q;
    o_err_d   = o_err_q;
    drop_d    = 1'b0;
    complete  = 1'b0;
    start_new = 1'b0;
    c_data    = a_data_q;
    c_len     = a_cnt_q;
    c_err     = a_err_q;

    if (o_valid_q && bus.dc_done_access) begin
      o_valid_d = 1'b0;
      o_data_d  = '0;
      o_len_d   = '0;
      o_err_d   = 1'b0;
    end

    unique case (state_q)
      StHold: complete = o_free;
      StIdle: start_new = flit_v;
      StAssemble: begin
        if (flit_v) begin
          if (ctrl == CtrlHead || ctrl == CtrlSingle) begin
            drop_d    = 1'b1;
            start_new = 1'b1;
          end else if (a_cnt_q < MaxLen) begin
            a_data_d = put_flit(a_data_q, a_cnt_q, flit);
            a_cnt_d  = a_cnt_q + 1'b1;
            if (ctrl == CtrlTail) begin
              complete = 1'b1;
              c_data   = a_data_d;
              c_len    = a_cnt_d;
            end
          end else if (ctrl == CtrlTail) begin
            complete = 1'b1;
            c_len    = MaxLen;
            c_err    = 1'b1;
          end else begin
            a_err_d = 1'b1;
            state_d = StOverflow;
          end
        end
      end
      StOverflow: begin
        if (flit_v) begin
          if (ctrl == CtrlHead || ctrl == CtrlSingle) begin
            drop_d    = 1'b1;
            start_new = 1'b1;
          end else if (ctrl == CtrlTail) begin
            complete = 1'b1;
            c_len    = MaxLen;
            c_err    = 1'b1;
          end
        end
      end
    endcase

    // Flit treated as arriving in IDLE (also after a discarded partial message).
    if (start_new) begin
      unique case (ctrl)
        CtrlHead: begin
          a_data_d = put_flit('0, '0, flit);
          a_cnt_d  = LEN_W'(1);
          a_err_d  = 1'b0;
          state_d  = StAssemble;
        end
        CtrlSingle: begin
          complete = 1'b1;
          c_data   = put_flit('0, '0, flit);
          c_len    = LEN_W'(1);
          c_err    = 1'b0;
        end
        default: begin
          drop_d  = 1'b1;
          state_d = StIdle;
        end
      endcase
    end

    if (complete) begin
      if (o_free) begin
        o_valid_d = 1'b1;
        o_data_d  = c_data;
        o_len_d   = c_len;
        o_err_d   = c_err;
        a_cnt_d   = '0;
        a_err_d   = 1'b0;
        state_d   = StIdle;
      end else begin
        a_data_d = c_data;
        a_cnt_d  = c_len;
        a_err_d  = c_err;
        state_d  = StHold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_data_q  <= '0;
      a_cnt_q   <= '0;
      a_err_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_len_q   <= '0;
      o_err_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_data_q  <= a_data_d;
      a_cnt_q   <= a_cnt_d;
      a_err_q   <= a_err_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_len_q   <= o_len_d;
      o_err_q   <= o_err_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.in_ready_dc       = (state_q != StHold);
  assign bus.v_dc_download     = o_valid_q;
  assign bus.dc_download_flits = o_data_q;
  assign bus.dc_download_len   = o_len_q;
  assign bus.dc_download_err   = o_err_q;
  assign bus.dc_download_state = state_q;
  assign bus.dc_drop           = drop_q;

endmodule

// File: tb/tb_dc_flit_assembler.sv
module tb_dc_flit_assembler;
  localparam int unsigned FW = 16;
  localparam int unsigned MF = 9;
  localparam int unsigned LW = 4;
  localparam int unsigned MW = FW * MF;

  logic clk;
  logic rst;

  dc_flit_assembler_if #(.FLIT_W(FW), .MAX_FLITS(MF), .LEN_W(LW)) bus ();

  dc_flit_assembler #(.FLIT_W(FW), .MAX_FLITS(MF), .LEN_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [MW-1:0] flits;
    logic [LW-1:0] len;
    logic          err;
  } msg_t;

  msg_t          exp_q[$];
  logic [FW-1:0] cur_q[$];
  bit            in_msg;
  bit            trunc;
  int            tests;
  int            fails;
  int            drop_exp;
  int            drop_seen;
  bit            cons_mode;
  bit            rand_done;
  bit            man_done;
  bit            saw_ovf;

  assign bus.dc_done_access = cons_mode ? rand_done : man_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  // Reference model over accepted flits: framing rules expressed with a flit queue.
  task automatic model_push(input bit err);
    msg_t m;
    m.flits = '0;
    foreach (cur_q[i]) m.flits[MW-1-i*FW -: FW] = cur_q[i];
    m.len = LW'(cur_q.size());
    m.err = err;
    exp_q.push_back(m);
  endtask

  task automatic model_accept(input logic [1:0] ctrl, input logic [FW-1:0] flit);
    if (ctrl == 2'b01 || ctrl == 2'b00) begin
      if (in_msg) drop_exp++;
      cur_q.delete();
      cur_q.push_back(flit);
      trunc = 0;
      if (ctrl == 2'b00) begin
        model_push(1'b0);
        in_msg = 0;
      end else begin
        in_msg = 1;
      end
    end else if (!in_msg) begin
      drop_exp++;
    end else begin
      if (cur_q.size() < MF) cur_q.push_back(flit);
      else trunc = 1;
      if (ctrl == 2'b11) begin
        model_push(trunc);
        in_msg = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] ctrl, input logic [FW-1:0] flit);
    bit acc;
    acc = 0;
    bus.IN_flit_dc      = flit;
    bus.In_flit_ctrl_dc = ctrl;
    bus.v_IN_flit_dc    = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      if (bus.in_ready_dc === 1'b1) begin
        @(posedge clk);
        model_accept(ctrl, flit);
        acc = 1;
      end else begin
        @(posedge clk);
      end
    end
    #1;
    bus.v_IN_flit_dc = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: flit %h not accepted, got ready=0, want ready=1", flit);
    end
  endtask

  task automatic consume();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    cons_mode = 1;
    while ((exp_q.size() != 0 || bus.v_dc_download) && c < 2000) begin
      tick();
      c++;
    end
    cons_mode = 0;
    tick();
    if (c >= 2000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
  endtask

  // Random consumer strobe, used only when cons_mode is set.
  initial begin
    rand_done = 0;
    forever begin
      @(posedge clk);
      #1;
      rand_done = ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: pops and compares on every consumed message; also checks O stability.
  initial begin
    msg_t          m;
    logic          pv, pd, pr;
    logic [MW-1:0] pf;
    pv = 0; pd = 0; pr = 1; pf = '0;
    forever begin
      @(negedge clk);
      if (bus.dc_drop === 1'b1) drop_seen++;
      if (bus.dc_download_state == 2'b10) saw_ovf = 1;
      if (pv && !pd && !pr) begin
        check("hold_valid", MW'(bus.v_dc_download), MW'(1));
        check("hold_flits", bus.dc_download_flits, pf);
      end
      if (bus.v_dc_download && bus.dc_done_access && !rst) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_msg: got %h, want no message", bus.dc_download_flits);
        end else begin
          m = exp_q.pop_front();
          check("msg_flits", bus.dc_download_flits, m.flits);
          check("msg_len", MW'(bus.dc_download_len), MW'(m.len));
          check("msg_err", MW'(bus.dc_download_err), MW'(m.err));
        end
      end
      pv = bus.v_dc_download;
      pd = bus.dc_done_access;
      pr = rst;
      pf = bus.dc_download_flits;
    end
  end

  initial begin
    logic [1:0] ctrl;
    int         r;
    rst = 1'b1;
    bus.v_IN_flit_dc    = 1'b0;
    bus.IN_flit_dc      = '0;
    bus.In_flit_ctrl_dc = '0;
    cons_mode = 0;
    man_done  = 0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", MW'(bus.v_dc_download), '0);
    check("rst_flits", bus.dc_download_flits, '0);
    check("rst_len", MW'(bus.dc_download_len), '0);
    check("rst_err", MW'(bus.dc_download_err), '0);
    check("rst_state", MW'(bus.dc_download_state), '0);
    check("rst_ready", MW'(bus.in_ready_dc), MW'(1));
    check("rst_drop", MW'(bus.dc_drop), '0);
    tick();

    // Full-length message
    send(2'b01, 16'h1111);
    for (int k = 2; k <= 8; k++) send(2'b10, FW'(k * 16'h1111));
    @(negedge clk);
    check("pre_tail_valid", MW'(bus.v_dc_download), '0);
    tick();
    send(2'b11, 16'h9999);
    @(negedge clk);
    check("nine_valid", MW'(bus.v_dc_download), MW'(1));
    check("nine_len", MW'(bus.dc_download_len), MW'(9));
    check("nine_err", MW'(bus.dc_download_err), '0);
    check("nine_flits", bus.dc_download_flits,
          144'h1111_2222_3333_4444_5555_6666_7777_8888_9999);
    tick();
    consume();

    // Short and single-flit messages
    send(2'b01, 16'hA000);
    send(2'b10, 16'hA001);
    send(2'b11, 16'hA002);
    @(negedge clk);
    check("three_hi", MW'(bus.dc_download_flits[143:96]), MW'(48'hA000_A001_A002));
    check("three_lo", MW'(bus.dc_download_flits[95:0]), '0);
    tick();
    consume();
    send(2'b00, 16'h00C2);
    @(negedge clk);
    check("single_len", MW'(bus.dc_download_len), MW'(1));
    check("single_hi", MW'(bus.dc_download_flits[143:128]), MW'(16'h00C2));
    tick();
    drain();

    // Second message held while O is unconsumed
    send(2'b01, 16'hB000);
    send(2'b10, 16'hB001);
    send(2'b11, 16'hB002);
    send(2'b01, 16'hC000);
    send(2'b10, 16'hC001);
    send(2'b11, 16'hC002);
    @(negedge clk);
    check("hold_state", MW'(bus.dc_download_state), MW'(2'b11));
    check("hold_ready", MW'(bus.in_ready_dc), '0);
    tick();
    consume();
    @(negedge clk);
    check("release_ready", MW'(bus.in_ready_dc), MW'(1));
    check("release_state", MW'(bus.dc_download_state), '0);
    check("release_flits", MW'(bus.dc_download_flits[143:96]), MW'(48'hC000_C001_C002));
    tick();
    consume();

    // Overflow: head + 10 bodies + tail
    saw_ovf = 0;
    send(2'b01, 16'hD000);
    for (int k = 1; k <= 10; k++) send(2'b10, FW'(16'hD000 + k));
    send(2'b11, 16'hD00B);
    @(negedge clk);
    check("ovf_len", MW'(bus.dc_download_len), MW'(9));
    check("ovf_err", MW'(bus.dc_download_err), MW'(1));
    check("ovf_state_seen", MW'(saw_ovf), MW'(1));
    tick();
    consume();

    // Framing errors
    send(2'b10, 16'hBEEF);
    @(negedge clk);
    check("stray_drop", MW'(bus.dc_drop), MW'(1));
    check("stray_valid", MW'(bus.v_dc_download), '0);
    tick();
    @(negedge clk);
    check("drop_one_cycle", MW'(bus.dc_drop), '0);
    tick();
    send(2'b01, 16'h1234);
    send(2'b10, 16'h4321);
    send(2'b01, 16'h5678);
    @(negedge clk);
    check("rehead_drop", MW'(bus.dc_drop), MW'(1));
    tick();
    send(2'b11, 16'h9ABC);
    @(negedge clk);
    check("rehead_len", MW'(bus.dc_download_len), MW'(2));
    check("rehead_hi", MW'(bus.dc_download_flits[143:112]), MW'(32'h5678_9ABC));
    tick();
    consume();

    // Reset mid-message
    send(2'b01, 16'hE000);
    for (int k = 1; k <= 3; k++) send(2'b10, FW'(16'hE000 + k));
    rst = 1'b1;
    in_msg = 0;
    cur_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", MW'(bus.v_dc_download), '0);
    check("midrst_state", MW'(bus.dc_download_state), '0);
    check("midrst_drop", MW'(bus.dc_drop), '0);
    check("midrst_flits", bus.dc_download_flits, '0);
    tick();
    send(2'b01, 16'hF000);
    send(2'b10, 16'hF001);
    send(2'b11, 16'hF002);
    drain();

    // Randomized traffic with random consumer
    cons_mode = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      r = $urandom_range(0, 9);
      ctrl = (r < 2) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00;
      send(ctrl, FW'($urandom));
    end
    drain();
    repeat (3) tick();

    check("drop_count", MW'(drop_seen), MW'(drop_exp));
    check("scoreboard_empty", MW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
